// File: rtl/wb_rr_arbiter_if.sv
// Bus-side signal bundle for the round-robin Wishbone arbiter.
// Carries per-master requests, slave-path responses, grant outputs and an FSM debug view.
interface wb_rr_arbiter_if #(
  parameter int NUMM = 3
);
  localparam int IW = (NUMM > 1) ? $clog2(NUMM) : 1;

  // Handshake: a master raises cyc_i[i] to request the bus and keeps it high for the
  // whole transfer; stb_i[i] marks a pending beat, completed by ack_i or err_i from the
  // slave path. The arbiter never drives the beat itself, it only owns gnt/err/timeout.
  logic [NUMM-1:0] cyc_i;
  logic [NUMM-1:0] stb_i;
  logic            ack_i;
  logic            err_i;
  logic [NUMM-1:0] gnt_o;
  logic [IW-1:0]   gnt_idx_o;
  logic            busy_o;
  logic [NUMM-1:0] err_o;
  logic            timeout_o;
  logic [1:0]      state_dbg;

  modport slave (
    input  cyc_i, stb_i, ack_i, err_i,
    output gnt_o, gnt_idx_o, busy_o, err_o, timeout_o, state_dbg
  );

  modport master (
    output cyc_i, stb_i, ack_i, err_i,
    input  gnt_o, gnt_idx_o, busy_o, err_o, timeout_o, state_dbg
  );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Round-robin arbiter for NUMM Wishbone masters with a stalled-strobe watchdog.
// Grants are held for the whole cyc, and a stalled owner is aborted with a one-cycle err.
module wb_rr_arbiter #(
  parameter int NUMM    = 3,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  wb_rr_arbiter_if.slave    bus
);
  localparam int IW = (NUMM > 1) ? $clog2(NUMM) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [IW:0]   NUMM_EXT = (IW + 1)'(NUMM);
  localparam logic [NUMM-1:0] ONE_HOT0 = {{(NUMM-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    ABORT = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [NUMM-1:0] gnt_q, gnt_d;
  logic [NUMM-1:0] err_q, err_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [IW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            to_q, to_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            owner_cyc;
  logic            owner_stb;
  logic            stall;

  // Scan from last+1 upward; iterating the offsets in descending order lets the
  // nearest requester overwrite farther ones, so the lowest offset wins.
  always_comb begin
    logic [IW:0] cand;
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int k = NUMM; k >= 1; k--) begin
      cand = {1'b0, last_q} + (IW + 1)'(k);
      if (cand >= NUMM_EXT) cand = cand - NUMM_EXT;
      if (bus.cyc_i[cand[IW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IW-1:0];
      end
    end
  end

  assign owner_cyc = bus.cyc_i[idx_q];
  assign owner_stb = bus.stb_i[idx_q];
  assign stall     = owner_stb & ~bus.ack_i & ~bus.err_i;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cnt_d   = '0;
    err_d   = '0;
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d = GRANT;
          gnt_d   = ONE_HOT0 << pick_idx;
          idx_d   = pick_idx;
          last_d  = pick_idx;
        end else begin
          gnt_d   = '0;
        end
      end
      GRANT: begin
        // Release beats the watchdog: a master dropping cyc is never aborted.
        if (!owner_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end else if (stall) begin
          if (cnt_q == CNT_LAST) begin
            state_d = ABORT;
            err_d   = gnt_q;
            to_d    = 1'b1;
          end else begin
            cnt_d   = cnt_q + CW'(1);
          end
        end
      end
      ABORT: begin
        if (!owner_cyc) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= IW'(NUMM - 1);
      cnt_q   <= '0;
      err_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      to_q    <= to_d;
    end
  end

  assign bus.gnt_o     = gnt_q;
  assign bus.gnt_idx_o = idx_q;
  assign bus.busy_o    = |gnt_q;
  assign bus.err_o     = err_q;
  assign bus.timeout_o = to_q;
  assign bus.state_dbg = state_q;
endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (NUMM=3, TIMEOUT=4) with a short invariant sweep.
module tb_wb_rr_arbiter;
  localparam int NUMM    = 3;
  localparam int TIMEOUT = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_ABORT = 2'd2;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_rr_arbiter_if #(.NUMM(NUMM)) bus ();

  wb_rr_arbiter #(.NUMM(NUMM), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  logic [NUMM-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // driver tasks
  task automatic drive(input logic [NUMM-1:0] cyc, input logic [NUMM-1:0] stb,
                       input logic ack, input logic err);
    bus.cyc_i = cyc;
    bus.stb_i = stb;
    bus.ack_i = ack;
    bus.err_i = err;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic [NUMM-1:0] gnt,
                           input logic [NUMM-1:0] err, input logic to, input logic [1:0] st);
    check({tag, "_gnt"}, 32'(bus.gnt_o), 32'(gnt));
    check({tag, "_err"}, 32'(bus.err_o), 32'(err));
    check({tag, "_to"},  32'(bus.timeout_o), 32'(to));
    check({tag, "_st"},  32'(bus.state_dbg), 32'(st));
  endtask

  logic [NUMM-1:0] rr_cyc [7];
  logic [NUMM-1:0] prev_gnt, prev_cyc, rc;

  initial begin
    drive('0, '0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    tick();
    check_out("reset", 3'b000, 3'b000, 1'b0, ST_IDLE);
    check("reset_idx",  32'(bus.gnt_idx_o), 32'd0);
    check("reset_busy", 32'(bus.busy_o), 32'd0);

    // rotation 0 -> 1 -> 2 -> 0 with an idle cycle between grants
    rr_cyc = '{3'b111, 3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011};
    exp_q  = '{3'b001, 3'b000, 3'b010, 3'b000, 3'b100, 3'b000, 3'b001};
    rst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      drive(rr_cyc[i], '0, 1'b0, 1'b0);
      tick();
      check($sformatf("rr%0d_gnt", i), 32'(bus.gnt_o), 32'(exp_q.pop_front()));
    end
    check("rr_idx0",  32'(bus.gnt_idx_o), 32'd0);
    check("rr_busy1", 32'(bus.busy_o), 32'd1);

    // owner 1 keeps the bus against competing requests
    drive(3'b110, '0, 1'b0, 1'b0); tick();
    check("hold_gap", 32'(bus.gnt_o), 32'd0);
    tick();
    check("hold_gnt", 32'(bus.gnt_o), 32'b010);
    check("hold_idx", 32'(bus.gnt_idx_o), 32'd1);
    drive(3'b111, '0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold%0d", i), 32'(bus.gnt_o), 32'b010);
    end
    drive(3'b000, '0, 1'b0, 1'b0); tick();
    check_out("hold_rel", 3'b000, 3'b000, 1'b0, ST_IDLE);
    check("idle_busy", 32'(bus.busy_o), 32'd0);

    // stalled owner 2 times out after TIMEOUT stall cycles
    drive(3'b100, 3'b100, 1'b0, 1'b0); tick();
    check_out("to_gnt", 3'b100, 3'b000, 1'b0, ST_GRANT);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out($sformatf("to_stall%0d", i), 3'b100, 3'b000, 1'b0, ST_GRANT);
    end
    tick();
    check_out("to_fire", 3'b100, 3'b100, 1'b1, ST_ABORT);
    tick();
    check_out("to_abort", 3'b100, 3'b000, 1'b0, ST_ABORT);
    tick();
    check_out("to_abort2", 3'b100, 3'b000, 1'b0, ST_ABORT);
    drive(3'b000, 3'b000, 1'b0, 1'b0); tick();
    check_out("to_rel", 3'b000, 3'b000, 1'b0, ST_IDLE);

    // ack on the would-expire cycle wins, then a full stall times out
    drive(3'b001, 3'b001, 1'b0, 1'b0); tick();
    check_out("ack_gnt", 3'b001, 3'b000, 1'b0, ST_GRANT);
    for (int i = 0; i < 3; i++) tick();
    check_out("ack_pre", 3'b001, 3'b000, 1'b0, ST_GRANT);
    drive(3'b001, 3'b001, 1'b1, 1'b0); tick();
    check_out("ack_win", 3'b001, 3'b000, 1'b0, ST_GRANT);
    drive(3'b001, 3'b001, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ack_restall%0d", i), 32'(bus.err_o), 32'd0);
    end
    tick();
    check_out("ack_to", 3'b001, 3'b001, 1'b1, ST_ABORT);
    drive(3'b000, 3'b000, 1'b0, 1'b0); tick();
    check_out("ack_rel", 3'b000, 3'b000, 1'b0, ST_IDLE);

    // reset mid-transfer drops grant silently; arbitration restarts from last=2
    drive(3'b010, 3'b010, 1'b0, 1'b0); tick();
    check_out("rst_gnt", 3'b010, 3'b000, 1'b0, ST_GRANT);
    tick(); tick();
    rst = 1'b1; tick();
    check_out("rst_mid", 3'b000, 3'b000, 1'b0, ST_IDLE);
    check("rst_mid_idx", 32'(bus.gnt_idx_o), 32'd0);
    rst = 1'b0;
    drive(3'b100, 3'b000, 1'b0, 1'b0); tick();
    check_out("rst_after", 3'b100, 3'b000, 1'b0, ST_GRANT);
    check("rst_after_idx", 32'(bus.gnt_idx_o), 32'd2);

    // random sweep: structural invariants every cycle
    for (int i = 0; i < 150; i++) begin
      prev_gnt = bus.gnt_o;
      rc = NUMM'($urandom_range(0, 7));
      if (prev_gnt != '0 && $urandom_range(0, 7) != 0) rc = rc | prev_gnt;
      drive(rc, NUMM'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 15) == 0));
      prev_cyc = bus.cyc_i;
      tick();
      check("inv_onehot", 32'($onehot0(bus.gnt_o)), 32'd1);
      if (bus.gnt_o != '0)
        check("inv_idx", 32'(bus.gnt_o), 32'(3'b001 << bus.gnt_idx_o));
      check("inv_err_sub", 32'(bus.err_o & ~bus.gnt_o), 32'd0);
      check("inv_to", 32'(bus.timeout_o), 32'(|bus.err_o));
      if ((prev_gnt & prev_cyc) != '0)
        check("inv_nopreempt", 32'(bus.gnt_o), 32'(prev_gnt));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
